// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: MIPS MEM pipeline stage with a registered MEM/WB output.
//
// Drives an external data memory through a req/ack handshake of variable
// latency and stalls upstream while an access is outstanding. Handles word,
// halfword and byte loads/stores (signed or unsigned loads) and flags
// misaligned, out-of-range and timed-out accesses.
//
// Ports:
//   in_clk, in_rst_n         clock (rising edge), async active-low reset
//   in_valid .. in_alu_result instruction fields from EX/MEM
//   out_stall                upstream must hold its inputs this cycle
//   mem_req/we/addr/be/wdata memory request, stable while mem_req is high
//   mem_rdata, mem_ack       memory response (ack is a one-cycle pulse)
//   out_*                    registered MEM/WB entry and exception flags
module pipe_mem_stage #(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int          ADDR_W    = 11,
  parameter int          MAX_WAIT  = 15
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_valid,
  input  logic              in_dmem_ena,
  input  logic              in_dmem_wena,
  input  logic [1:0]        in_dmem_type,
  input  logic              in_load_signed,
  input  logic [31:0]       in_rt_data,
  input  logic [4:0]        in_rd_waddr,
  input  logic              in_rd_sel,
  input  logic              in_rd_wena,
  input  logic [31:0]       in_alu_result,
  output logic              out_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [4:0]        out_rd_waddr,
  output logic              out_rd_sel,
  output logic              out_rd_wena,
  output logic [31:0]       out_alu_result,
  output logic [31:0]       out_dmem_data,
  output logic              out_exc_misalign,
  output logic              out_exc_range,
  output logic              out_exc_timeout
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [32:0] SPAN   = 33'd1 << (ADDR_W + 2);
  localparam logic [7:0]  CNT_LAST = 8'(MAX_WAIT - 1);

  state_t state, state_nxt;

  // Request held for the duration of WAIT; r_* feed the memory pins directly.
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [1:0]        r_lane;
  logic [1:0]        r_type;
  logic              r_signed;
  logic              r_rd_wena;
  logic [7:0]        cnt;

  // ---------------- address decode and store formatting ----------------
  logic [31:0] offset;
  logic        is_half, is_byte, is_word;
  logic        misalign, range_err, exc_any, start;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  assign offset    = in_alu_result - BASE_ADDR;  // wraps, so below-base is huge
  assign is_half   = (in_dmem_type == 2'b01);
  assign is_byte   = (in_dmem_type == 2'b10);
  assign is_word   = !is_half && !is_byte;
  assign misalign  = (is_half && offset[0]) || (is_word && (offset[1:0] != 2'b00));
  assign range_err = ({1'b0, offset} >= SPAN);
  assign exc_any   = misalign || range_err;
  assign start     = (state == S_IDLE) && in_valid && in_dmem_ena && !exc_any;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = in_rt_data;
    if (is_byte) begin
      st_be    = 4'b0001 << offset[1:0];
      st_wdata = {4{in_rt_data[7:0]}};
    end else if (is_half) begin
      st_be    = offset[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{in_rt_data[15:0]}};
    end
  end

  // ---------------- load formatting (little-endian lanes) ----------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    case (r_lane)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_type)
      2'b10:   ld_data = r_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      2'b01:   ld_data = r_signed ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // ---------------- FSM ----------------
  logic timeout_now;
  assign timeout_now = (state == S_WAIT) && !mem_ack && (cnt == CNT_LAST);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_stall = 1'b0;
    case (state)
      S_IDLE: begin
        out_stall = start;
        if (start) state_nxt = S_WAIT;
      end
      default: begin
        // Stall drops on the ack cycle and on the final timeout cycle so
        // upstream advances on the same edge that retires this access.
        out_stall = !mem_ack && !timeout_now;
        if (mem_ack || timeout_now) state_nxt = S_IDLE;
      end
    endcase
  end

  // mem_req comes straight from the state register, so an async reset
  // withdraws it immediately.
  assign mem_req   = (state == S_WAIT);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

  // ---------------- request capture and MEM/WB register ----------------
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_we             <= 1'b0;
      r_addr           <= '0;
      r_be             <= '0;
      r_wdata          <= '0;
      r_lane           <= '0;
      r_type           <= '0;
      r_signed         <= 1'b0;
      r_rd_wena        <= 1'b0;
      cnt              <= '0;
      out_valid        <= 1'b0;
      out_rd_waddr     <= '0;
      out_rd_sel       <= 1'b0;
      out_rd_wena      <= 1'b0;
      out_alu_result   <= '0;
      out_dmem_data    <= '0;
      out_exc_misalign <= 1'b0;
      out_exc_range    <= 1'b0;
      out_exc_timeout  <= 1'b0;
    end else begin
      // Bubble by default; flags only ever accompany out_valid.
      out_valid        <= 1'b0;
      out_exc_misalign <= 1'b0;
      out_exc_range    <= 1'b0;
      out_exc_timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // Pass-through fields park in the output register; they stay
            // put through WAIT since nothing else writes them there.
            out_rd_waddr   <= in_rd_waddr;
            out_rd_sel     <= in_rd_sel;
            out_alu_result <= in_alu_result;
            out_dmem_data  <= '0;
            if (!in_dmem_ena) begin
              out_valid   <= 1'b1;
              out_rd_wena <= in_rd_wena;
            end else if (exc_any) begin
              out_valid        <= 1'b1;
              out_rd_wena      <= 1'b0;
              out_exc_misalign <= misalign;
              out_exc_range    <= !misalign;
            end else begin
              out_rd_wena <= 1'b0;
              r_we        <= in_dmem_wena;
              r_addr      <= offset[ADDR_W+1:2];
              r_be        <= in_dmem_wena ? st_be : 4'b1111;
              r_wdata     <= st_wdata;
              r_lane      <= offset[1:0];
              r_type      <= in_dmem_type;
              r_signed    <= in_load_signed;
              r_rd_wena   <= in_rd_wena;
              cnt         <= '0;
            end
          end
        end
        default: begin
          if (mem_ack) begin
            out_valid     <= 1'b1;
            out_rd_wena   <= r_rd_wena;
            out_dmem_data <= r_we ? 32'h0 : ld_data;
            cnt           <= '0;
          end else if (timeout_now) begin
            out_valid       <= 1'b1;
            out_exc_timeout <= 1'b1;
            out_rd_wena     <= 1'b0;
            out_dmem_data   <= '0;
            cnt             <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_mem_stage.md
Name: pipe_mem_stage

Overview:
Parametrised MIPS MEM pipeline stage with a registered MEM/WB output. It drives an external data memory through a req/ack handshake with variable latency, and stalls upstream while a memory access is outstanding. It supports word, halfword and byte loads and stores with signed or unsigned loads. It also flags misaligned, out-of-range and timed-out accesses.

Parameters:
BASE_ADDR, 32'h10010000, byte address mapped to memory word 0
ADDR_W, 11, memory word-address width (depth = 2^ADDR_W words)
MAX_WAIT, 15, WAIT cycles without ack before timeout (range 1..255)

Ports:
in_clk  input  1  clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction present this cycle
in_dmem_ena  input  1  instruction accesses memory
in_dmem_wena  input  1  1 = store, 0 = load
in_dmem_type  input  2  00 word, 01 half, 10 byte, 11 treated as word
in_load_signed  input  1  sign-extend half/byte loads
in_rt_data  input  32  store data
in_rd_waddr  input  5  destination register
in_rd_sel  input  1  WB mux select, passed through
in_rd_wena  input  1  register write enable
in_alu_result  input  32  effective byte address / ALU result
out_stall  output  1  upstream must hold inputs
mem_req  output  1  memory request, held until ack or timeout
mem_we  output  1  write request
mem_addr  output  ADDR_W  word address
mem_be  output  4  byte enables, lane k = bits [8k+7:8k]
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  read data, valid when mem_ack
mem_ack  input  1  access complete (one cycle)
out_valid  output  1  MEM/WB entry valid
out_rd_waddr  output  5  registered
out_rd_sel  output  1  registered
out_rd_wena  output  1  registered; forced 0 on any exception
out_alu_result  output  32  registered
out_dmem_data  output  32  formatted load data (0 for stores/non-mem)
out_exc_misalign  output  1  registered, one cycle with out_valid
out_exc_range  output  1  registered
out_exc_timeout  output  1  registered

Behaviour:
- The already-decided interface is one clock, in_clk; reset is asynchronous and active-low, in_rst_n.
- Reset values: all registered outputs are 0, mem_req is 0, the state is IDLE and the wait counter is 0. Reset mid-access abandons the request immediately; an ack received afterwards is ignored.
- offset = in_alu_result - BASE_ADDR, computed modulo 2^32.
- Range error: offset >= 4*2^ADDR_W (this includes addresses below BASE_ADDR).
- Misalign error: half with offset[0]=1; word with offset[1:0]!=0. Misalign takes priority over range if both apply.
- mem_addr = offset[ADDR_W+1:2]; lane k = offset[1:0].
- Store byte enables and data:
  - byte: be = 0001<<k, wdata = {4{rt[7:0]}}
  - half: be = 0011<<(2*offset[1]), wdata = {2{rt[15:0]}}
  - word: be = 1111, wdata = rt
- Load formatting (little-endian): extract the selected byte or halfword lane, then zero- or sign-extend it per in_load_signed.
- FSM IDLE:
  - in_valid & !in_dmem_ena: register the pass-through fields and set out_valid=1 on the next edge; no stall (1-cycle latency).
  - in_valid & in_dmem_ena & exception: no mem_req and no stall; next edge sets out_valid=1, the matching exc flag, out_rd_wena=0 and out_dmem_data=0.
  - in_valid & in_dmem_ena & no exception: out_stall=1 combinationally; capture the request and pass-through fields; go to WAIT with counter=0.
  - !in_valid: out_valid=0 on the next edge.
- FSM WAIT:
  - mem_req=1 with stable mem_we/addr/be/wdata, driven from registers.
  - out_stall = !mem_ack; upstream inputs are ignored.
  - On mem_ack: next edge sets out_valid=1 with load data formatted (stores: out_dmem_data=0), mem_req drops, go to IDLE.
  - Otherwise counter++. On the edge where counter reaches MAX_WAIT: mem_req drops, out_valid=1, out_exc_timeout=1, out_rd_wena=0, go to IDLE, and the stall releases in that same cycle.
- Minimum memory-op latency is 2 cycles from presentation to out_valid (ack in the first WAIT cycle).
- out_valid=0 during every stalled cycle (bubble to WB). Exception flags are valid only together with out_valid.
- mem_ack while in IDLE is ignored.

Test Plan:
- Non-mem op, alu=32'h1234, rd=5, rd_wena=1 -> next cycle out_valid=1, out_alu_result=32'h1234, out_rd_waddr=5, no stall, mem_req=0.
- Word load at alu=32'h10010008, ack after 3 cycles with rdata=32'hDEADBEEF:
  - mem_addr=2, be=1111, out_stall high for 4 cycles.
  - out_dmem_data=32'hDEADBEEF, with out_valid=1 only after ack.
- Byte loads at 32'h10010003, rdata=32'h80FF7F01:
  - signed -> 32'hFFFFFF80
  - unsigned -> 32'h00000080
  - Halfword signed load at offset 2 -> 32'hFFFF80FF.
- Half store of rt=32'h0000ABCD at 32'h10010006 -> be=1100, wdata=32'hABCDABCD, mem_we=1.
- Exception checks (no mem_req, no stall, out_rd_wena=0 in each case):
  - word load at 32'h10010002 -> exc_misalign=1
  - word load at 32'h0FFFFFFC -> exc_range=1
  - word load at 32'h10012000 (ADDR_W=11) -> exc_range=1
- Timeout and reset:
  - No ack with MAX_WAIT=15 -> mem_req high 15 cycles, then exc_timeout=1 and stall released.
  - Assert in_rst_n=0 in the 2nd WAIT cycle -> mem_req=0 immediately and a later ack has no effect.
